// File: rtl/alu_issue_pkg.sv
// Purpose: shared constants and the instruction decoder for the ALU issue stage.
// Latency: n/a (package; the decode function is purely combinational).
// Backpressure: n/a.
package alu_issue_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // ALU control codes
    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_SLL  = 4'h3;
    localparam logic [3:0] ALU_SRL  = 4'h4;
    localparam logic [3:0] ALU_SRA  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_XOR  = 4'h8;
    localparam logic [3:0] ALU_OR   = 4'h9;
    localparam logic [3:0] ALU_AND  = 4'hA;

    // Major opcodes
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    // funct7 variants
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic       legal;     // decodable OP / OP-IMM
        logic       uses_rs2;  // OP reads rs2; OP-IMM uses the immediate instead
        logic [3:0] cntrl;     // ALU code, ALU_NOP when not legal
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic       is_op;
        logic       is_imm;
        logic       f7_base;
        logic       f7_alt;
        logic       plain_ok;
        d        = '0;
        is_op    = (instr[6:0] == OPC_OP);
        is_imm   = (instr[6:0] == OPC_OPIMM);
        f7_base  = (instr[31:25] == F7_BASE);
        f7_alt   = (instr[31:25] == F7_ALT);
        // Non-shift OP-IMM forms carry immediate bits in [31:25], so funct7 is ignored there.
        plain_ok = is_imm || f7_base;
        if (is_op || is_imm) begin
            d.uses_rs2 = is_op;
            case (instr[14:12])
                F3_ADD_SUB: begin
                    if (plain_ok)            begin d.legal = 1'b1; d.cntrl = ALU_ADD; end
                    else if (f7_alt)         begin d.legal = 1'b1; d.cntrl = ALU_SUB; end
                end
                F3_SLL:     if (f7_base)     begin d.legal = 1'b1; d.cntrl = ALU_SLL;  end
                F3_SRL_SRA: begin
                    if (f7_base)             begin d.legal = 1'b1; d.cntrl = ALU_SRL; end
                    else if (f7_alt)         begin d.legal = 1'b1; d.cntrl = ALU_SRA; end
                end
                F3_SLT:     if (plain_ok)    begin d.legal = 1'b1; d.cntrl = ALU_SLT;  end
                F3_SLTU:    if (plain_ok)    begin d.legal = 1'b1; d.cntrl = ALU_SLTU; end
                F3_XOR:     if (plain_ok)    begin d.legal = 1'b1; d.cntrl = ALU_XOR;  end
                F3_OR:      if (plain_ok)    begin d.legal = 1'b1; d.cntrl = ALU_OR;   end
                F3_AND:     if (plain_ok)    begin d.legal = 1'b1; d.cntrl = ALU_AND;  end
                default: ;
            endcase
        end
        if (!d.legal) begin
            d.uses_rs2 = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// Purpose: 32-entry register file, two operand read ports, one debug read port, one write port.
// Latency: reads combinational; a write at posedge is visible on reads the following cycle.
// Backpressure: none; the write port always accepts.
//
// Ports: clk, rst_n (sync, active-low, clears every entry); rd_addr_a/b -> rd_data_a/b;
//        dbg_addr -> dbg_data; wr_en/wr_addr/wr_data write port (writes to x0 are dropped).
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int XW = XLEN,
    parameter int AW = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr_a,
    output logic [XW-1:0] rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [XW-1:0] rd_data_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [XW-1:0] dbg_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [XW-1:0] wr_data
);

    localparam int NREGS = 2 ** AW;

    logic [XW-1:0] regs_q [NREGS];
    logic [XW-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != '0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
    assign dbg_data  = (dbg_addr  == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Purpose: decode/issue of RV32 OP / OP-IMM into the ALU, with WB forwarding and writeback.
// Latency: accept at E0 drives ALU operands, ALU result captured at E1, regfile written at E2.
// Backpressure: instr_ready drops for one cycle when the op in EX produces a source of the new op.
//
// Ports: clk, rst_n (sync, active-low); instr_valid/instr/instr_ready handshake;
//        alu_rs1/alu_rs2/alu_cntrl registered ALU drive, alu_out registered ALU result;
//        illegal one-cycle pulse; retired writeback count; dbg_addr/dbg_data regfile peek.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN_P       = XLEN,
    parameter int REG_ADDR_W_P = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    input  logic [31:0]             instr,
    output logic                    instr_ready,
    output logic [XLEN_P-1:0]       alu_rs1,
    output logic [XLEN_P-1:0]       alu_rs2,
    output logic [3:0]              alu_cntrl,
    input  logic [XLEN_P-1:0]       alu_out,
    output logic                    illegal,
    output logic [31:0]             retired,
    input  logic [REG_ADDR_W_P-1:0] dbg_addr,
    output logic [XLEN_P-1:0]       dbg_data
);

    dec_t                    dec;
    logic [REG_ADDR_W_P-1:0] rs1_a, rs2_a, rd_a;
    logic [XLEN_P-1:0]       imm;
    logic [XLEN_P-1:0]       rf_rs1, rf_rs2, src1, src2;
    logic                    fwd_ok, hazard, fire, issue;

    logic                    ex_valid_q, ex_valid_d;
    logic [REG_ADDR_W_P-1:0] ex_rd_q, ex_rd_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [REG_ADDR_W_P-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN_P-1:0]       alu_rs1_q, alu_rs1_d;
    logic [XLEN_P-1:0]       alu_rs2_q, alu_rs2_d;
    logic [3:0]              alu_cntrl_q, alu_cntrl_d;
    logic                    illegal_q, illegal_d;
    logic [31:0]             retired_q, retired_d;

    assign dec   = decode(instr);
    assign rs1_a = instr[19:15];
    assign rs2_a = instr[24:20];
    assign rd_a  = instr[11:7];
    assign imm   = {{(XLEN_P-12){instr[31]}}, instr[31:20]};

    alu_issue_regfile #(
        .XW (XLEN_P),
        .AW (REG_ADDR_W_P)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rs1_a),
        .rd_data_a (rf_rs1),
        .rd_addr_b (rs2_a),
        .rd_data_b (rf_rs2),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wb_valid_q),
        .wr_addr   (wb_rd_q),
        .wr_data   (alu_out)
    );

    // The op in WB has its result on alu_out but not yet in the regfile. x0 never
    // forwards (wb_rd != 0), so the regfile's forced zero covers it.
    assign fwd_ok = wb_valid_q && (wb_rd_q != '0);
    assign src1   = (fwd_ok && (wb_rd_q == rs1_a)) ? alu_out : rf_rs1;
    assign src2   = (fwd_ok && (wb_rd_q == rs2_a)) ? alu_out : rf_rs2;

    // The op in EX has no result anywhere yet: a dependent op waits one cycle,
    // after which the producer sits in WB and the forward path covers it.
    assign hazard = dec.legal && ex_valid_q && (ex_rd_q != '0) &&
                    ((ex_rd_q == rs1_a) || (dec.uses_rs2 && (ex_rd_q == rs2_a)));

    assign instr_ready = rst_n && !hazard;
    assign fire        = instr_valid && instr_ready;
    assign issue       = fire && dec.legal;

    always_comb begin
        ex_valid_d  = issue;
        ex_rd_d     = issue ? rd_a : '0;
        alu_cntrl_d = issue ? dec.cntrl : ALU_NOP;
        alu_rs1_d   = issue ? src1 : '0;
        alu_rs2_d   = issue ? (dec.uses_rs2 ? src2 : imm) : '0;
        illegal_d   = fire && !dec.legal;
        wb_valid_d  = ex_valid_q;
        wb_rd_d     = ex_rd_q;
        retired_d   = retired_q + 32'(wb_valid_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            alu_rs1_q   <= '0;
            alu_rs2_q   <= '0;
            alu_cntrl_q <= ALU_NOP;
            illegal_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            alu_rs1_q   <= alu_rs1_d;
            alu_rs2_q   <= alu_rs2_d;
            alu_cntrl_q <= alu_cntrl_d;
            illegal_q   <= illegal_d;
            retired_q   <= retired_d;
        end
    end

    assign alu_rs1   = alu_rs1_q;
    assign alu_rs2   = alu_rs2_q;
    assign alu_cntrl = alu_cntrl_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Purpose: self-checking bench for alu_issue_stage with an ALU stand-in and an ISA-level model.
// Latency: n/a.
// Backpressure: sender holds instr_valid until instr_ready, counting stall cycles.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_rs1, alu_rs2, alu_out;
    logic [3:0]  alu_cntrl;
    logic        illegal;
    logic [31:0] retired;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_rs1     (alu_rs1),
        .alu_rs2     (alu_rs2),
        .alu_cntrl   (alu_cntrl),
        .alu_out     (alu_out),
        .illegal     (illegal),
        .retired     (retired),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Mnemonic index 0..9: add sub sll srl sra slt sltu xor or and (ALU code = index + 1)
    localparam logic [2:0] F3S [10] = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd5, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
    localparam logic [6:0] F7S [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'h1: return a + b;
            4'h2: return a - b;
            4'h3: return a << b[4:0];
            4'h4: return a >> b[4:0];
            4'h5: return $unsigned($signed(a) >>> b[4:0]);
            4'h6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return a ^ b;
            4'h9: return a | b;
            4'hA: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // ALU stand-in: registered result of whatever is issued.
    always @(posedge clk) alu_out <= alu_ref(alu_cntrl, alu_rs1, alu_rs2);

    function automatic logic [31:0] enc(input bit is_op, input int idx, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        logic [11:0] i12;
        if (is_op) return {F7S[idx], rs2, rs1, F3S[idx], rd, 7'h33};
        i12 = (idx >= 2 && idx <= 4) ? {F7S[idx], imm[4:0]} : imm;
        return {i12, rs1, F3S[idx], rd, 7'h13};
    endfunction

    int checks = 0;
    int errors = 0;
    int ret_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present w until accepted; returns one time unit after the accepting edge.
    task automatic send(input logic [31:0] w, input bit legal, output int stalls);
        instr       = w;
        instr_valid = 1'b1;
        stalls      = 0;
        #1;
        while (!instr_ready && stalls < 8) begin
            @(posedge clk);
            #2;
            stalls++;
        end
        if (!instr_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr_ready stayed 0, expected 1 within 8 cycles");
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        if (legal) ret_exp++;
    endtask

    task automatic dbg(input logic [4:0] a, input string name, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    typedef struct {
        logic [31:0] w;
        logic [3:0]  cntrl;
        logic        ill;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [31:0] w, input logic [3:0] c, input logic ill,
                           input logic [31:0] b, input logic [31:0] res);
        vec_t v;
        v.w = w; v.cntrl = c; v.ill = ill; v.b = b; v.res = res;
        tbl.push_back(v);
    endtask

    logic [31:0] arch [32];

    initial begin
        int st;
        // Sweep with x5 = 0x80000000, x6 = 1, results to x7.
        add_vec(enc(1, 0, 7, 5, 6, 0), 4'h1, 0, 32'h1, 32'h80000001);
        add_vec(enc(1, 1, 7, 5, 6, 0), 4'h2, 0, 32'h1, 32'h7FFFFFFF);
        add_vec(enc(1, 2, 7, 5, 6, 0), 4'h3, 0, 32'h1, 32'h00000000);
        add_vec(enc(1, 3, 7, 5, 6, 0), 4'h4, 0, 32'h1, 32'h40000000);
        add_vec(enc(1, 4, 7, 5, 6, 0), 4'h5, 0, 32'h1, 32'hC0000000);
        add_vec(enc(1, 5, 7, 5, 6, 0), 4'h6, 0, 32'h1, 32'h00000001);
        add_vec(enc(1, 6, 7, 5, 6, 0), 4'h7, 0, 32'h1, 32'h00000000);
        add_vec(enc(1, 7, 7, 5, 6, 0), 4'h8, 0, 32'h1, 32'h80000001);
        add_vec(enc(1, 8, 7, 5, 6, 0), 4'h9, 0, 32'h1, 32'h80000001);
        add_vec(enc(1, 9, 7, 5, 6, 0), 4'hA, 0, 32'h1, 32'h00000000);
        add_vec(enc(0, 0, 7, 5, 0, 12'hFFF), 4'h1, 0, 32'hFFFFFFFF, 32'h7FFFFFFF);
        add_vec(enc(0, 5, 7, 5, 0, 12'h000), 4'h6, 0, 32'h00000000, 32'h00000001);
        add_vec(enc(0, 6, 7, 5, 0, 12'hFFF), 4'h7, 0, 32'hFFFFFFFF, 32'h00000001);
        add_vec(enc(0, 4, 7, 5, 0, 12'd4),   4'h5, 0, 32'h00000404, 32'hF8000000);
        add_vec(enc(0, 3, 7, 5, 0, 12'd31),  4'h4, 0, 32'h0000001F, 32'h00000001);
        add_vec(enc(0, 7, 7, 5, 0, 12'h7FF), 4'h8, 0, 32'h000007FF, 32'h800007FF);
        add_vec(32'h0000007F, 4'h0, 1, 32'h0, 32'h0);
        add_vec({7'h01, 5'd6, 5'd5, 3'd0, 5'd7, 7'h33}, 4'h0, 1, 32'h0, 32'h0);
        add_vec({7'h20, 5'd1, 5'd5, 3'd1, 5'd7, 7'h13}, 4'h0, 1, 32'h0, 32'h0);
        add_vec({7'h20, 5'd6, 5'd5, 3'd1, 5'd7, 7'h33}, 4'h0, 1, 32'h0, 32'h0);

        rst_n = 1'b0; instr_valid = 1'b0; instr = 32'h0; dbg_addr = 5'd0;
        idle(2);
        rst_n = 1'b1;
        #1;
        chk("rst_alu_rs1", alu_rs1, 0);
        chk("rst_alu_rs2", alu_rs2, 0);
        chk("rst_alu_cntrl", {28'h0, alu_cntrl}, 0);
        chk("rst_illegal", {31'h0, illegal}, 0);
        chk("rst_retired", retired, 0);
        chk("rst_ready", {31'h0, instr_ready}, 1);

        // 1) two addi with an idle gap
        send(enc(0, 0, 1, 0, 0, 12'd5), 1, st);
        idle(2);
        send(enc(0, 0, 2, 0, 0, 12'hFFD), 1, st);
        idle(3);
        dbg(1, "t1_x1", 32'd5);
        dbg(2, "t1_x2", 32'hFFFFFFFD);
        chk("t1_retired", retired, 32'd2);

        // 2) WB forwarding of both operands
        send(enc(0, 0, 1, 0, 0, 12'd7), 1, st);
        send(enc(0, 0, 4, 0, 0, 12'd0), 1, st);
        send(enc(1, 0, 3, 1, 1, 0), 1, st);
        chk("t2_stalls", st, 0);
        chk("t2_rs1", alu_rs1, 32'd7);
        chk("t2_rs2", alu_rs2, 32'd7);
        idle(3);
        dbg(3, "t2_x3", 32'd14);

        // 3) EX hazard: exactly one stall cycle
        send(enc(0, 0, 1, 0, 0, 12'd1), 1, st);
        send(enc(0, 2, 2, 1, 0, 12'd4), 1, st);
        chk("t3_stalls", st, 1);
        chk("t3_rs1", alu_rs1, 32'd1);
        idle(3);
        dbg(2, "t3_x2", 32'd16);

        // 4) table sweep
        send(enc(0, 0, 5, 0, 0, 12'd1), 1, st);
        send(enc(0, 2, 5, 5, 0, 12'd31), 1, st);
        send(enc(0, 0, 6, 0, 0, 12'd1), 1, st);
        idle(3);
        foreach (tbl[i]) begin
            send(tbl[i].w, !tbl[i].ill, st);
            chk($sformatf("tbl%0d_cntrl", i), {28'h0, alu_cntrl}, {28'h0, tbl[i].cntrl});
            chk($sformatf("tbl%0d_illegal", i), {31'h0, illegal}, {31'h0, tbl[i].ill});
            if (!tbl[i].ill) begin
                chk($sformatf("tbl%0d_rs1", i), alu_rs1, 32'h80000000);
                chk($sformatf("tbl%0d_rs2", i), alu_rs2, tbl[i].b);
            end
            idle(3);
            if (!tbl[i].ill) dbg(7, $sformatf("tbl%0d_x7", i), tbl[i].res);
        end
        chk("t4_retired", retired, ret_exp);

        // 5) illegal then addi x0: single pulse, x0 untouched, only addi retires
        send(32'h0000007F, 0, st);
        chk("t5_illegal_pulse", {31'h0, illegal}, 1);
        chk("t5_bubble", {28'h0, alu_cntrl}, 0);
        send(enc(0, 0, 0, 0, 0, 12'd9), 1, st);
        chk("t5_illegal_once", {31'h0, illegal}, 0);
        chk("t5_addi_cntrl", {28'h0, alu_cntrl}, 1);
        idle(3);
        dbg(0, "t5_x0", 32'd0);
        chk("t5_retired", retired, ret_exp);

        // 6) reset with an add in flight
        send(enc(1, 0, 3, 1, 1, 0), 1, st);
        rst_n = 1'b0;
        #1;
        chk("t6_ready_in_reset", {31'h0, instr_ready}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ret_exp = 0;
        #1;
        chk("t6_alu_rs1", alu_rs1, 0);
        chk("t6_alu_rs2", alu_rs2, 0);
        chk("t6_alu_cntrl", {28'h0, alu_cntrl}, 0);
        chk("t6_illegal", {31'h0, illegal}, 0);
        chk("t6_retired", retired, 0);
        idle(3);
        chk("t6_retired_later", retired, 0);
        dbg(3, "t6_x3", 32'd0);

        // Random program against the architectural model
        begin
            int prev_rd;
            prev_rd = -1;
            foreach (arch[i]) arch[i] = 32'h0;
            idle(1);
            for (int n = 0; n < 300; n++) begin
                int kind, idx, exp_st;
                bit is_op, legal;
                logic [4:0] rd, r1, r2;
                logic [11:0] imm;
                logic [31:0] w, a, b;
                if ($urandom_range(0, 3) == 0) begin
                    idle($urandom_range(1, 2));
                    prev_rd = -1;
                end
                kind  = $urandom_range(0, 19);
                idx   = $urandom_range(0, 9);
                rd    = 5'($urandom_range(0, 7));
                r1    = 5'($urandom_range(0, 7));
                r2    = 5'($urandom_range(0, 7));
                imm   = 12'($urandom);
                legal = (kind != 0);
                is_op = (kind < 10);
                if (!is_op && idx == 1) idx = 0;
                if (legal) begin
                    w = enc(is_op, idx, rd, r1, r2, imm);
                end else begin
                    w = $urandom;
                    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[6:0] = 7'h7F;
                end
                exp_st = (legal && prev_rd > 0 &&
                          (int'(r1) == prev_rd || (is_op && int'(r2) == prev_rd))) ? 1 : 0;
                send(w, legal, st);
                chk($sformatf("rnd%0d_stalls", n), st, exp_st);
                chk($sformatf("rnd%0d_illegal", n), {31'h0, illegal}, {31'h0, !legal});
                chk($sformatf("rnd%0d_cntrl", n), {28'h0, alu_cntrl}, legal ? idx + 1 : 0);
                if (legal) begin
                    a = arch[r1];
                    b = is_op ? arch[r2] : {{20{w[31]}}, w[31:20]};
                    chk($sformatf("rnd%0d_rs1", n), alu_rs1, a);
                    chk($sformatf("rnd%0d_rs2", n), alu_rs2, b);
                    if (rd != 0) arch[rd] = alu_ref(4'(idx + 1), a, b);
                    prev_rd = int'(rd);
                end else begin
                    prev_rd = -1;
                end
            end
            idle(3);
            for (int r = 0; r < 8; r++) dbg(5'(r), $sformatf("rnd_x%0d", r), arch[r]);
            chk("rnd_retired", retired, ret_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
